// File: rtl/region_capture_80x40.sv
// Captures plotted pixels that land inside a fixed 80x40 screen window into a
// 3200x9 RAM, counts accepted writes and exposes a registered read-back port.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | waiting for start; plots ignored
//   CAPTURE | accepting in-window plots, flagging out-of-window ones
//   DONE    | window count reached; plots ignored until next start
module region_capture_80x40 #(
    parameter int ORIGIN_X = 39,
    parameter int ORIGIN_Y = 39,
    parameter int WIDTH    = 80,
    parameter int HEIGHT   = 40
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       plot,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [8:0] colour,
    input  logic [6:0] rd_x,
    input  logic [5:0] rd_y,
    output logic [8:0] rd_colour,
    output logic       busy,
    output logic       capture_done,
    output logic [11:0] pixel_count,
    output logic       oob_error
);

    localparam int         DEPTH  = WIDTH * HEIGHT;
    localparam logic [8:0] X_LO   = 9'(ORIGIN_X);
    localparam logic [8:0] X_HI   = 9'(ORIGIN_X + WIDTH);
    localparam logic [7:0] Y_LO   = 8'(ORIGIN_Y);
    localparam logic [7:0] Y_HI   = 8'(ORIGIN_Y + HEIGHT);
    localparam logic [11:0] W12   = 12'(WIDTH);
    localparam logic [11:0] TOTAL = 12'(DEPTH);
    localparam logic [11:0] LAST  = 12'(DEPTH - 1);
    localparam logic [6:0] RX_LIM = 7'(WIDTH);
    localparam logic [5:0] RY_LIM = 6'(HEIGHT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state, next_state;

    logic        clear;
    logic        accept;
    logic        oob_hit;
    logic [8:0]  x_ext;
    logic [7:0]  y_ext;
    logic [8:0]  x_off;
    logic [7:0]  y_off;
    logic        in_win;
    logic [11:0] wr_addr;
    logic [11:0] rd_addr;
    logic        rd_in;

    logic [8:0] mem [0:DEPTH-1];

    // Widened compares keep origin+size from wrapping at the 8/7-bit port widths.
    assign x_ext   = {1'b0, x};
    assign y_ext   = {1'b0, y};
    assign in_win  = (x_ext >= X_LO) && (x_ext < X_HI) &&
                     (y_ext >= Y_LO) && (y_ext < Y_HI);
    assign x_off   = x_ext - X_LO;
    assign y_off   = y_ext - Y_LO;
    assign wr_addr = 12'(y_off) * W12 + 12'(x_off);

    assign rd_in   = (rd_x < RX_LIM) && (rd_y < RY_LIM);
    assign rd_addr = 12'(rd_y) * W12 + 12'(rd_x);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A plot coinciding with start is dropped: start wins and re-arms.
    always_comb begin
        next_state = state;
        clear      = 1'b0;
        accept     = 1'b0;
        oob_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = CAPTURE;
                    clear      = 1'b1;
                end
            end
            CAPTURE: begin
                if (start) begin
                    clear = 1'b1;
                end else if (plot) begin
                    if (in_win) begin
                        accept = 1'b1;
                        if (pixel_count == LAST) begin
                            next_state = DONE;
                        end
                    end else begin
                        oob_hit = 1'b1;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    next_state = CAPTURE;
                    clear      = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pixel_count  <= '0;
            oob_error    <= 1'b0;
            busy         <= 1'b0;
            capture_done <= 1'b0;
        end else begin
            busy         <= (next_state == CAPTURE);
            capture_done <= (next_state == DONE);
            if (clear) begin
                pixel_count <= '0;
                oob_error   <= 1'b0;
            end else begin
                if (accept && (pixel_count != TOTAL)) begin
                    pixel_count <= pixel_count + 12'd1;
                end
                if (oob_hit) begin
                    oob_error <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_addr] <= colour;
        end
    end

    // Non-blocking read of the array gives read-before-write on an address collision.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_colour <= '0;
        end else if (rd_in) begin
            rd_colour <= mem[rd_addr];
        end else begin
            rd_colour <= '0;
        end
    end

endmodule

// File: tb/tb_region_capture_80x40.sv
// Directed bench for region_capture_80x40: stimulus queues expected status and
// read-back values with the cycle they are due; a negedge monitor compares them.
module tb_region_capture_80x40;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        plot;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [8:0]  colour;
    logic [6:0]  rd_x;
    logic [5:0]  rd_y;
    logic [8:0]  rd_colour;
    logic        busy;
    logic        capture_done;
    logic [11:0] pixel_count;
    logic        oob_error;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        string      name;
        logic [8:0] exp;
        int         due;
    } rd_item_t;

    typedef struct {
        string       name;
        logic        busy;
        logic        done;
        logic [11:0] cnt;
        logic        oob;
        int          due;
    } st_item_t;

    rd_item_t rd_q[$];
    st_item_t st_q[$];

    region_capture_80x40 dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .plot         (plot),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .rd_x         (rd_x),
        .rd_y         (rd_y),
        .rd_colour    (rd_colour),
        .busy         (busy),
        .capture_done (capture_done),
        .pixel_count  (pixel_count),
        .oob_error    (oob_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        rd_item_t ri;
        st_item_t si;
        while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            ri = rd_q.pop_front();
            checks++;
            if (rd_colour !== ri.exp) begin
                failures++;
                $display("FAIL %s: rd_colour got %h want %h", ri.name, rd_colour, ri.exp);
            end
        end
        while (st_q.size() > 0 && st_q[0].due <= cyc) begin
            si = st_q.pop_front();
            checks++;
            if (busy !== si.busy || capture_done !== si.done ||
                pixel_count !== si.cnt || oob_error !== si.oob) begin
                failures++;
                $display("FAIL %s: busy/done/count/oob got %b/%b/%0d/%b want %b/%b/%0d/%b",
                         si.name, busy, capture_done, pixel_count, oob_error,
                         si.busy, si.done, si.cnt, si.oob);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_status(input string nm, input logic b, input logic d,
                              input logic [11:0] c, input logic o);
        st_item_t it;
        it.name = nm; it.busy = b; it.done = d; it.cnt = c; it.oob = o; it.due = cyc;
        st_q.push_back(it);
    endtask

    // Present a read address now; expected data is due after the next edge.
    task automatic rd_req(input string nm, input logic [6:0] rx, input logic [5:0] ry,
                          input logic [8:0] e);
        rd_item_t it;
        rd_x = rx;
        rd_y = ry;
        it.name = nm; it.exp = e; it.due = cyc + 1;
        rd_q.push_back(it);
    endtask

    task automatic rd_now(input string nm, input logic [8:0] e);
        rd_item_t it;
        it.name = nm; it.exp = e; it.due = cyc;
        rd_q.push_back(it);
    endtask

    task automatic drive_plot(input logic p, input logic [7:0] px, input logic [6:0] py,
                              input logic [8:0] pc);
        plot = p; x = px; y = py; colour = pc;
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        drive_plot(1'b0, 8'd0, 7'd0, 9'd0);
        rd_x = 7'd0;
        rd_y = 6'd0;
        exp_status("reset_state", 1'b0, 1'b0, 12'd0, 1'b0);
        rd_now("reset_rd", 9'd0);
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // Full raster capture
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_status("capture_entry", 1'b1, 1'b0, 12'd0, 1'b0);
        for (int i = 0; i < 3200; i++) begin
            drive_plot(1'b1, 8'(39 + i % 80), 7'(39 + i / 80), 9'(i % 512));
            tick();
            if (i == 0)    exp_status("first_plot", 1'b1, 1'b0, 12'd1, 1'b0);
            if (i == 3198) exp_status("before_last", 1'b1, 1'b0, 12'd3199, 1'b0);
        end
        plot = 1'b0;
        exp_status("capture_done", 1'b0, 1'b1, 12'd3200, 1'b0);

        // Plot in DONE is ignored
        drive_plot(1'b1, 8'd40, 7'd40, 9'h000);
        tick();
        plot = 1'b0;
        exp_status("done_plot_ignored", 1'b0, 1'b1, 12'd3200, 1'b0);

        rd_req("rd_0_0", 7'd0, 6'd0, 9'd0);
        tick();
        rd_req("rd_79_0", 7'd79, 6'd0, 9'd79);
        tick();
        rd_req("rd_0_39", 7'd0, 6'd39, 9'd48);
        tick();
        rd_req("rd_79_39", 7'd79, 6'd39, 9'd127);
        tick();
        rd_req("rd_1_1_done", 7'd1, 6'd1, 9'd81);
        tick();

        // 100 accepted plots on local rows 10..11, then async reset mid-cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 800; i < 900; i++) begin
            drive_plot(1'b1, 8'(39 + i % 80), 7'(39 + i / 80), 9'((i + 7) % 512));
            tick();
        end
        plot = 1'b0;
        exp_status("hundred_plots", 1'b1, 1'b0, 12'd100, 1'b0);
        tick();
        #2;
        resetn = 1'b0;
        #1;
        exp_status("async_reset", 1'b0, 1'b0, 12'd0, 1'b0);
        rd_now("async_reset_rd", 9'd0);
        tick();
        tick();
        resetn = 1'b1;

        // Plots in IDLE after reset are ignored
        drive_plot(1'b1, 8'd40, 7'd40, 9'h1FF);
        tick();
        tick();
        plot = 1'b0;
        exp_status("idle_plot_ignored", 1'b0, 1'b0, 12'd0, 1'b0);
        rd_req("rd_1_1_idle", 7'd1, 6'd1, 9'd81);
        tick();
        rd_req("rd_retained", 7'd0, 6'd10, 9'd295);
        tick();

        // Out-of-window plots during CAPTURE
        start = 1'b1;
        tick();
        start = 1'b0;
        drive_plot(1'b1, 8'd38, 7'd39, 9'h001);
        tick();
        exp_status("oob_left", 1'b1, 1'b0, 12'd0, 1'b1);
        drive_plot(1'b1, 8'd119, 7'd50, 9'h002);
        tick();
        drive_plot(1'b1, 8'd50, 7'd79, 9'h003);
        tick();
        exp_status("oob_right_bottom", 1'b1, 1'b0, 12'd0, 1'b1);
        drive_plot(1'b1, 8'd118, 7'd78, 9'h033);
        tick();
        exp_status("corner_accept", 1'b1, 1'b0, 12'd1, 1'b1);
        start = 1'b1;
        drive_plot(1'b1, 8'd39, 7'd39, 9'h111);
        tick();
        start = 1'b0;
        plot  = 1'b0;
        exp_status("restart_clears", 1'b1, 1'b0, 12'd0, 1'b0);
        rd_req("start_plot_ignored", 7'd0, 6'd0, 9'd0);
        tick();
        rd_req("rd_corner", 7'd79, 6'd39, 9'h033);
        tick();

        // Same-cycle read and write of local (5,5)
        drive_plot(1'b1, 8'd44, 7'd44, 9'h0AA);
        tick();
        drive_plot(1'b1, 8'd44, 7'd44, 9'h155);
        rd_req("rbw_old", 7'd5, 6'd5, 9'h0AA);
        tick();
        plot = 1'b0;
        exp_status("rbw_count", 1'b1, 1'b0, 12'd2, 1'b0);
        rd_req("rbw_new", 7'd5, 6'd5, 9'h155);
        tick();
        rd_req("rd_x_80", 7'd80, 6'd0, 9'd0);
        tick();
        rd_req("rd_y_40", 7'd0, 6'd40, 9'd0);
        tick();

        for (int i = 0; i < 4; i++) tick();
        if (rd_q.size() != 0 || st_q.size() != 0) begin
            failures += rd_q.size() + st_q.size();
            $display("FAIL drain: pending read=%0d status=%0d want 0/0", rd_q.size(), st_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/region_capture_80x40.md
Name: region_capture_80x40

Overview:
- Receiving end of the pixel-stream interface (x, y, colour, plot) that the stage/banner draw blocks drive toward the VGA adapter.
- Captures one fixed-origin 80x40 window of plotted pixels into internal 9-bit-per-pixel storage, counts accepted pixels and flags completion.
- Provides a registered read-back port so a bench, or a later "compare/restore background" block, can fetch captured colours by local coordinate.

Parameters:
ORIGIN_X, 39, screen x of window's top-left pixel
ORIGIN_Y, 39, screen y of window's top-left pixel
WIDTH, 80, window width in pixels
HEIGHT, 40, window height in pixels

Ports:
clk  input  1  system clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; arms or re-arms capture
plot  input  1  pixel-valid strobe from draw block
x  input  8  screen x of plotted pixel
y  input  7  screen y of plotted pixel
colour  input  9  3-3-3 RGB of plotted pixel
rd_x  input  7  local read x (0..WIDTH-1)
rd_y  input  6  local read y (0..HEIGHT-1)
rd_colour  output  9  captured colour at (rd_x, rd_y), registered
busy  output  1  high while in CAPTURE
capture_done  output  1  high in DONE until next start or reset
pixel_count  output  12  accepted in-window writes since last start
oob_error  output  1  sticky: a plot outside the window arrived during CAPTURE

Behaviour:
- Reset (async, resetn=0): state=IDLE; busy=0, capture_done=0, pixel_count=0, oob_error=0, rd_colour=0. Storage contents are not cleared.
- FSM states: IDLE, CAPTURE, DONE.
  - IDLE -> CAPTURE on start.
  - CAPTURE -> DONE on the cycle the accepted write makes pixel_count reach WIDTH*HEIGHT (3200).
  - DONE -> CAPTURE on start.
  - start in CAPTURE restarts: pixel_count=0, oob_error=0, stays CAPTURE.
  - Every entry to CAPTURE clears pixel_count and oob_error. A plot in the same cycle as start is ignored.
- Window test:
  - in_win = (x >= ORIGIN_X) && (x < ORIGIN_X+WIDTH) && (y >= ORIGIN_Y) && (y < ORIGIN_Y+HEIGHT).
  - Compare in 9-bit x / 8-bit y so origin+size does not overflow.
- Accept: plot && in_win && state==CAPTURE && !start.
  - Write colour to address (y-ORIGIN_Y)*WIDTH + (x-ORIGIN_X), 12 bits.
  - pixel_count increments by 1.
  - The write is visible to the read port from the next cycle.
- Duplicate coordinates count again; completion is purely count-based.
- plot && !in_win in CAPTURE: pixel dropped, not counted, oob_error set (sticky).
- Plots in IDLE or DONE are ignored entirely and do not set oob_error.
- busy = (state==CAPTURE); capture_done = (state==DONE). Both are registered and update the cycle after the triggering edge.
- pixel_count saturates at 3200; it holds its value in DONE.
- Read port:
  - rd_colour updates one clock after rd_x/rd_y are presented, in all states.
  - If rd_x >= WIDTH or rd_y >= HEIGHT, rd_colour=0 on the next cycle.
  - Read and write to the same address in one cycle: rd_colour returns old data (read-before-write).
- Storage is inferrable as single-clock dual-port RAM, 3200x9.
- Reset asserted mid-CAPTURE aborts immediately; partially written data is retained but pixel_count=0.

Test Plan:
1. Reset, pulse start, stream all 3200 window pixels (raster order from (39,39) to (118,78), colour = local index mod 512), one per cycle -> busy high throughout; capture_done rises the cycle after the 3200th plot; pixel_count=3200; oob_error=0.
2. After scenario 1, read (0,0), (79,0), (0,39), (79,39) -> rd_colour = 0, 79, 3120 mod 512 = 48, 3199 mod 512 = 127, each one cycle after its address.
3. In CAPTURE, plot (38,39), (119,50), (50,79) -> no pixel_count change, oob_error=1; next start clears oob_error to 0.
4. Plot in IDLE at (40,40) colour 9'h1FF, then in DONE at (40,40) colour 9'h000 -> pixel_count unchanged, readback of local (1,1) shows the last in-CAPTURE value.
5. Start, 100 accepted plots, assert resetn=0 asynchronously between edges -> all outputs go to 0 without waiting for a clock; after release state=IDLE and plots are ignored until start.
6. Read and write local (5,5) in the same cycle with old=9'h0AA, new=9'h155 -> rd_colour=9'h0AA; re-read next cycle -> 9'h155. Then present rd_x=80 -> rd_colour=0.
